// File: rtl/speed_unit_if.sv
// ---- speed_unit_if : reed/circumference inputs and speed outputs of speed_unit (rev 1.0) ----
`default_nettype none

interface speed_unit_if;
   logic       reed;
   logic [7:0] circ;
   logic [6:0] speed;
   logic [6:0] max_speed;
   logic       moving;
   logic       speed_upd;
   logic       busy;

   modport master (
      output reed, circ,
      input  speed, max_speed, moving, speed_upd, busy
   );

   modport slave (
      input  reed, circ,
      output speed, max_speed, moving, speed_upd, busy
   );
endinterface

`default_nettype wire

// File: rtl/speed_unit.sv
// ---- speed_unit : reed-pulse interval to current/maximum speed in km/h, sequential divider (rev 1.0) ----
`default_nettype none

module speed_unit #(
   parameter int F_CLK     = 2048,
   parameter int SPEED_MAX = 99
) (
   input  wire logic   clock,
   input  wire logic   reset,
   speed_unit_if.slave bus
);

   // circ*DIV_K / (N*125) = km/h; TO_K is DIV_K/3, i.e. the 3 km/h floor
   localparam logic [21:0] C_DIV_K      = 22'(F_CLK * 9 / 2);
   localparam logic [19:0] C_TO_K       = 20'(F_CLK * 3 / 2);
   localparam logic [19:0] C_N_SCALE    = 20'd125;
   localparam logic [21:0] C_SPEED_MAXW = 22'(SPEED_MAX);
   localparam logic [6:0]  C_SPEED_MAX7 = 7'(SPEED_MAX);
   localparam logic [4:0]  C_DIV_STEPS  = 5'd22;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_reed_q;
   logic [12:0] r_cnt;
   logic        r_busy;
   logic [4:0]  r_bit_cnt;
   logic [19:0] r_rem;
   logic [21:0] r_quo;
   logic [19:0] r_dvs;
   logic [6:0]  r_speed;
   logic [6:0]  r_max;
   logic        r_upd;

   logic        w_edge;
   logic        w_timeout_hit;
   logic        w_start_div;
   logic        w_clr_cnt;
   logic        w_timeout;
   logic [19:0] w_cnt_scaled;
   logic [19:0] w_limit;
   logic [12:0] w_n_meas;
   logic [19:0] w_divisor;
   logic [21:0] w_dividend;
   logic [20:0] w_shift;
   logic [21:0] w_diff;
   logic [19:0] w_rem_nxt;
   logic [21:0] w_quo_nxt;
   logic [6:0]  w_speed_sat;

   assign w_edge        = bus.reed & ~r_reed_q;
   assign w_cnt_scaled  = 20'(r_cnt) * C_N_SCALE;
   assign w_limit       = 20'(bus.circ) * C_TO_K;
   assign w_timeout_hit = ~r_busy & (w_cnt_scaled > w_limit);

   // Counter holds cycles-since-edge minus one, so the interval is cnt+1
   assign w_n_meas   = (r_cnt == 13'h1FFF) ? r_cnt : r_cnt + 13'd1;
   assign w_divisor  = 20'(w_n_meas) * C_N_SCALE;
   assign w_dividend = 22'(bus.circ) * C_DIV_K;

   assign w_shift     = {r_rem, r_quo[21]};
   assign w_diff      = {1'b0, w_shift} - {2'b00, r_dvs};
   assign w_rem_nxt   = w_diff[21] ? w_shift[19:0] : w_diff[19:0];
   assign w_quo_nxt   = {r_quo[20:0], ~w_diff[21]};
   assign w_speed_sat = (w_quo_nxt > C_SPEED_MAXW) ? C_SPEED_MAX7 : w_quo_nxt[6:0];

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start_div = 1'b0;
      w_clr_cnt   = 1'b0;
      w_timeout   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_edge) begin
               w_state_nxt = RUN;
               w_clr_cnt   = 1'b1;
            end
         end
         RUN: begin
            if (w_timeout_hit) begin
               w_timeout   = 1'b1;
               w_clr_cnt   = 1'b1;
               w_state_nxt = IDLE;
            end else if (w_edge) begin
               w_clr_cnt   = 1'b1;
               w_start_div = ~r_busy;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_reed_q  <= 1'b0;
         r_cnt     <= 13'd0;
         r_busy    <= 1'b0;
         r_bit_cnt <= 5'd0;
         r_rem     <= 20'd0;
         r_quo     <= 22'd0;
         r_dvs     <= 20'd0;
         r_speed   <= 7'd0;
         r_max     <= 7'd0;
         r_upd     <= 1'b0;
      end else begin
         r_reed_q <= bus.reed;
         r_upd    <= 1'b0;

         if (w_clr_cnt) begin
            r_cnt <= 13'd0;
         end else if (r_state == RUN && r_cnt != 13'h1FFF) begin
            r_cnt <= r_cnt + 13'd1;
         end

         if (w_timeout) begin
            r_speed <= 7'd0;
            r_upd   <= 1'b1;
         end

         if (w_start_div) begin
            r_busy    <= 1'b1;
            r_bit_cnt <= C_DIV_STEPS;
            r_rem     <= 20'd0;
            r_quo     <= w_dividend;
            r_dvs     <= w_divisor;
         end else if (r_busy) begin
            r_rem     <= w_rem_nxt;
            r_quo     <= w_quo_nxt;
            r_bit_cnt <= r_bit_cnt - 5'd1;
            if (r_bit_cnt == 5'd1) begin
               r_busy  <= 1'b0;
               r_speed <= w_speed_sat;
               r_upd   <= 1'b1;
            end
         end

         if (r_upd && r_speed > r_max) begin
            r_max <= r_speed;
         end
      end
   end

   assign bus.speed     = r_speed;
   assign bus.max_speed = r_max;
   assign bus.moving    = (r_state == RUN);
   assign bus.speed_upd = r_upd;
   assign bus.busy      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_speed_unit.sv
// ---- tb_speed_unit : directed vectors and corner sequences for speed_unit (rev 1.0) ----
`default_nettype none

module tb_speed_unit;

   logic clock = 1'b0;
   logic reset;

   speed_unit_if bus ();

   speed_unit #(
      .F_CLK    (2048),
      .SPEED_MAX(99)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      int   period;
      int   hold;
      logic exp_upd;
      int   exp_speed;
      int   exp_max;
   } vec_t;

   vec_t vecs [7];

   int vectors  = 0;
   int errors   = 0;
   int since    = 0;
   int hold_len = 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One clock; inputs and samples both land 1 time unit after the rising edge
   task automatic step();
      @(posedge clock);
      #1;
      since++;
      if (since >= hold_len) bus.reed = 1'b0;
   endtask

   task automatic fire(input int hold);
      bus.reed = 1'b1;
      since    = 0;
      hold_len = hold;
   endtask

   task automatic wait_until(input int n);
      while (since < n) step();
   endtask

   initial begin
      int n_upd;
      int n_busy;

      vecs[0] = '{5,    1,  1'b0, 0,  0};
      vecs[1] = '{2048, 1,  1'b1, 9,  9};
      vecs[2] = '{200,  1,  1'b1, 94, 94};
      vecs[3] = '{2048, 1,  1'b1, 9,  94};
      vecs[4] = '{188,  1,  1'b1, 99, 99};
      vecs[5] = '{200,  50, 1'b1, 94, 99};
      vecs[6] = '{200,  1,  1'b1, 94, 99};

      reset    = 1'b1;
      bus.reed = 1'b0;
      bus.circ = 8'd255;
      repeat (3) step();
      chk("reset speed",  32'(bus.speed), 0);
      chk("reset max",    32'(bus.max_speed), 0);
      chk("reset moving", 32'(bus.moving), 0);
      chk("reset upd",    32'(bus.speed_upd), 0);
      chk("reset busy",   32'(bus.busy), 0);
      reset = 1'b0;
      since = 0;

      for (int i = 0; i < 7; i++) begin
         wait_until(vecs[i].period);
         fire(vecs[i].hold);
         step();
         chk($sformatf("v%0d busy", i), 32'(bus.busy), 32'(vecs[i].exp_upd));
         repeat (22) step();
         chk($sformatf("v%0d upd", i),    32'(bus.speed_upd), 32'(vecs[i].exp_upd));
         chk($sformatf("v%0d speed", i),  32'(bus.speed), 32'(vecs[i].exp_speed));
         chk($sformatf("v%0d moving", i), 32'(bus.moving), 1);
         step();
         chk($sformatf("v%0d max", i),     32'(bus.max_speed), 32'(vecs[i].exp_max));
         chk($sformatf("v%0d upd off", i), 32'(bus.speed_upd), 0);
      end

      // Reset in the middle of a running division
      wait_until(200);
      fire(1);
      repeat (10) step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("midrst speed",  32'(bus.speed), 0);
      chk("midrst max",    32'(bus.max_speed), 0);
      chk("midrst moving", 32'(bus.moving), 0);
      chk("midrst busy",   32'(bus.busy), 0);
      chk("midrst upd",    32'(bus.speed_upd), 0);
      n_upd  = 0;
      n_busy = 0;
      repeat (25) begin
         step();
         n_upd  += int'(bus.speed_upd);
         n_busy += int'(bus.busy);
      end
      chk("midrst later strobes", 32'(n_upd), 0);
      chk("midrst later busy", 32'(n_busy), 0);

      // Back-to-back with circ=10: second edge dropped, counter restarts there
      bus.circ = 8'd10;
      fire(1);
      wait_until(10);
      fire(1);
      step();
      chk("b2b busy", 32'(bus.busy), 1);
      wait_until(10);
      fire(1);
      wait_until(13);
      chk("b2b upd",   32'(bus.speed_upd), 1);
      chk("b2b speed", 32'(bus.speed), 73);
      step();
      chk("b2b max", 32'(bus.max_speed), 73);
      n_upd = 0;
      while (since < 30) begin
         step();
         n_upd += int'(bus.speed_upd);
      end
      chk("b2b dropped strobe", 32'(n_upd), 0);
      fire(1);
      repeat (23) step();
      chk("b2b next upd",   32'(bus.speed_upd), 1);
      chk("b2b next speed", 32'(bus.speed), 24);
      step();
      chk("b2b next max", 32'(bus.max_speed), 73);

      // Timeout at circ=10: compare first true at counter 246
      wait_until(247);
      chk("to10 moving before", 32'(bus.moving), 1);
      chk("to10 upd before",    32'(bus.speed_upd), 0);
      step();
      chk("to10 moving", 32'(bus.moving), 0);
      chk("to10 speed",  32'(bus.speed), 0);
      chk("to10 upd",    32'(bus.speed_upd), 1);
      step();
      chk("to10 upd off", 32'(bus.speed_upd), 0);
      chk("to10 max",     32'(bus.max_speed), 73);

      // Timeout at circ=255: compare first true at counter 6267
      bus.circ = 8'd255;
      step();
      fire(1);
      step();
      chk("to255 arm busy",   32'(bus.busy), 0);
      chk("to255 arm moving", 32'(bus.moving), 1);
      wait_until(6268);
      chk("to255 moving before", 32'(bus.moving), 1);
      step();
      chk("to255 moving", 32'(bus.moving), 0);
      chk("to255 speed",  32'(bus.speed), 0);
      chk("to255 upd",    32'(bus.speed_upd), 1);
      step();
      fire(1);
      n_upd  = 0;
      n_busy = 0;
      repeat (30) begin
         step();
         n_upd  += int'(bus.speed_upd);
         n_busy += int'(bus.busy);
      end
      chk("rearm strobes", 32'(n_upd), 0);
      chk("rearm busy",    32'(n_busy), 0);
      chk("rearm moving",  32'(bus.moving), 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/speed_unit.md
# speed_unit

Wheel-speed measurement stage of the bicycle computer. It sits directly upstream of the display/mode block: it turns raw reed-contact pulses and the configured wheel circumference into the current speed and the maximum speed, both in integer km/h. It also drives a `moving` flag that gates trip-time and average-speed accumulation downstream. Division is done by a multi-cycle sequential divider, so there is no combinational divide.

## Interface
Parameters
- `F_CLK`, 2048: clock frequency in Hz. Constants below are derived for 2048; other values are unsupported.
- `SPEED_MAX`, 99: saturation value for the speed outputs (two display digits).

Ports. One clock; reset is synchronous and active-high.
- `clock`  in  1  system clock, 2048 Hz
- `reset`  in  1  synchronous, active-high; clears all state
- `reed`  in  1  reed contact level, already synchronous to `clock`
- `circ`  in  8  wheel circumference in cm, 1..255; static while moving
- `speed`  out  7  current speed, km/h, 0..99
- `max_speed`  out  7  maximum `speed` since reset
- `moving`  out  1  1 while the wheel is considered turning
- `speed_upd`  out  1  one-cycle strobe; `speed` was rewritten this cycle
- `busy`  out  1  divider running

## Operation
- **Edge detect.** `reed` is registered. An edge is counted in cycle E when `reed`=1 at E and `reed`=0 at E-1. A held-high `reed` produces one edge.
- **Interval counter.**
  - Cleared on every edge.
  - Otherwise increments by 1 while `moving`=1, saturating at 8191 (13 bits).
  - At an edge, N is the number of cycles since the previous edge.
- **States.**
  - **IDLE** (`moving`=0). An edge sets `moving`, clears the counter and goes to RUN. `speed` is unchanged (0). No division is started.
  - **RUN**. An edge with the divider idle captures N and `circ`, clears the counter and starts a division. `moving` stays 1.
  - **RUN timeout.** When counter×125 > `circ`×3072 (below 3 km/h), `speed`←0, `moving`←0, `speed_upd`=1, counter cleared, return to IDLE.
  - **RUN edge while `busy`=1.** The counter still clears, but that interval is dropped (no new division). The running division completes normally.
- **Arithmetic.**
  - Dividend = `circ`×9216 (22 bits, max 2 350 080).
  - Divisor = N×125 (20 bits).
  - 9216/125 = 2048×3600/100000 (cm per clock → km/h).
  - Quotient truncates toward zero.
  - If quotient > `SPEED_MAX`, `speed` = `SPEED_MAX`.
  - Restoring division with one quotient bit per cycle, 22 iterations.
- **Max.** If `speed` > `max_speed`, `max_speed` ← `speed` one cycle after `speed_upd`. It never decreases except on reset.
- **Timeout during division.** A timeout cannot occur while `busy`=1, because the counter is far below any threshold during the 22 cycles.
- **Reset.** Reset mid-division aborts it with no `speed_upd`.

## Timing
- **Reset values.** `speed`=0, `max_speed`=0, `moving`=0, `speed_upd`=0, `busy`=0. Divider, counter and edge register are cleared.
- **Division latency.**
  - Edge in cycle E: operands latched at E, `busy`=1 from E+1 through E+22.
  - `speed` and `speed_upd`=1 at E+23.
  - `max_speed` valid at E+24.
- **Timeout latency.** The threshold compare is registered. `speed`←0 and `moving`←0 one cycle after the counter first satisfies the compare.
- **Strobe.** `speed_upd` is exactly one cycle wide and is also asserted when the new `speed` equals the old one.
- **Minimum interval.** Edges spaced ≥ 24 cycles are all measured.
- **Reset priority.** `reset` has priority over every other event in the same cycle.

## Test plan
- **Reset.** Assert `reset` mid-division → next cycle all outputs 0, `busy`=0, no `speed_upd`.
- **First edge.** `circ`=255, single pulse → `moving`=1, `speed`=0, no `speed_upd`. A second pulse 2048 cycles later → `speed`=9 exactly 23 cycles after that edge, `max_speed`=9 one cycle after.
- **Normal and clamp.** `circ`=255, period 200 → `speed`=94. Period 188 → quotient 100, `speed`=99 (clamp), `max_speed`=99.
- **Max holds.** Period 200, then period 2048 → `speed` 94 then 9, `max_speed` stays 94. A held-high `reed` for 50 cycles counts as a single edge.
- **Timeout.** `circ`=255, one edge, then no edges → counter reaches 6267, next cycle `speed`=0, `moving`=0, `speed_upd`=1. A following edge only re-arms (no division).
- **Back-to-back.** `circ`=10, edges 10 cycles apart → the second edge is dropped while `busy`. The completed result reflects the first interval only, and the counter restarts at the dropped edge.
